// File: rtl/sram_fifo_ctrl_pkg.sv
// sram_fifo_ctrl_pkg: shared sizing helpers and output-buffer occupancy states.
package sram_fifo_ctrl_pkg;
  typedef enum logic [1:0] {OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_TWO = 2'd2} occ_e;
  function automatic int depth_of(input int addr_bits);
    return 1 << addr_bits;
  endfunction
  function automatic int ptr_w(input int addr_bits);
    return addr_bits + 1;
  endfunction
  function automatic int cnt_w(input int addr_bits);
    return addr_bits + 2;
  endfunction
endpackage

// File: rtl/sram_fifo_ctrl_outbuf.sv
// sram_fifo_ctrl_outbuf: 2-entry skid buffer holding words returned by the SRAM.
module sram_fifo_ctrl_outbuf
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            occ
);
  occ_e state, state_nxt;
  logic [DATA_WIDTH-1:0] head, tail;
  logic [1:0] occ_nxt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= OCC_EMPTY;
    else state <= state_nxt;
  end
  always_comb begin
    occ_nxt = 2'(state) + {1'b0, push} - {1'b0, pop};
    state_nxt = occ_e'(occ_nxt);
  end
  // Data registers need no reset: occupancy alone qualifies them.
  always_ff @(posedge i_clk) begin
    if (pop) head <= (state == OCC_TWO) ? tail : push_data;
    else if (push && state == OCC_EMPTY) head <= push_data;
    if (push && (state == OCC_TWO || (state == OCC_ONE && !pop))) tail <= push_data;
  end
  assign occ = 2'(state);
  assign valid = state != OCC_EMPTY;
  assign data = head;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO over a 1-cycle-latency SRAM with a 2-word output buffer.
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_BITS+1:0]  o_count,
  output logic [ADDR_BITS-1:0]  o_sram_waddr,
  output logic [DATA_WIDTH-1:0] o_sram_wdata,
  output logic                  o_sram_we,
  output logic [ADDR_BITS-1:0]  o_sram_raddr,
  input  logic [DATA_WIDTH-1:0] i_sram_rdata
);
  localparam int DEPTH = depth_of(ADDR_BITS);
  localparam int PTR_W = ptr_w(ADDR_BITS);
  localparam int CNT_W = cnt_w(ADDR_BITS);
  logic [PTR_W-1:0] wr_ptr, rd_ptr, unfetched;
  logic inflight, issue, pop, full;
  logic [1:0] occ;
  assign unfetched = wr_ptr - rd_ptr;
  assign full = unfetched == PTR_W'(DEPTH);
  assign o_wr_ready = i_rst_n & ~full;
  assign o_sram_we = i_wr_valid & o_wr_ready;
  assign o_sram_waddr = wr_ptr[ADDR_BITS-1:0];
  assign o_sram_wdata = i_wr_data;
  assign o_sram_raddr = rd_ptr[ADDR_BITS-1:0];
  assign pop = o_rd_valid & i_rd_ready;
  // Issue only if the word will have a buffer slot when it returns next cycle.
  assign issue = (unfetched != '0) && (({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
  assign o_count = CNT_W'(unfetched) + CNT_W'(inflight) + CNT_W'(occ);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      inflight <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(o_sram_we);
      rd_ptr <= rd_ptr + PTR_W'(issue);
      inflight <= issue;
    end
  end
  sram_fifo_ctrl_outbuf #(.DATA_WIDTH(DATA_WIDTH)) u_outbuf (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push     (inflight),
    .push_data(i_sram_rdata),
    .pop      (pop),
    .valid    (o_rd_valid),
    .data     (o_rd_data),
    .occ      (occ)
  );
endmodule
